control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer_pkg.sv | 66 ++++++
 rtl/control_decode.sv | 49 ++++
 rtl/control_sequencer.sv | 153 +++++++++++++++
 tb/tb_control_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared encodings for the instruction-fetch control sequencer: states, opcodes,
// decode result codes and the instruction length table.
package control_sequencer_pkg;

  typedef enum logic [2:0] {
    S_START  = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_INT    = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP  = 3'd0,
    CLS_ALU  = 3'd1,
    CLS_JUMP = 3'd2,
    CLS_CALL = 3'd3,
    CLS_RET  = 3'd4
  } class_e;

  // MOV A,Rn occupies E8..EF; the low three bits select the register
  localparam logic [7:0] OP_MOV_A_RN = 8'hE8;
  localparam logic [7:0] OP_ADD_IMM  = 8'h24;
  localparam logic [7:0] OP_SUBB_IMM = 8'h94;
  localparam logic [7:0] OP_ANL_IMM  = 8'h54;
  localparam logic [7:0] OP_ORL_IMM  = 8'h44;
  localparam logic [7:0] OP_XRL_IMM  = 8'h64;
  localparam logic [7:0] OP_JZ       = 8'h60;
  localparam logic [7:0] OP_JNZ      = 8'h70;
  localparam logic [7:0] OP_JNC      = 8'h50;
  localparam logic [7:0] OP_AJMP     = 8'h01;
  localparam logic [7:0] OP_ACALL    = 8'h11;
  localparam logic [7:0] OP_LJMP     = 8'h02;
  localparam logic [7:0] OP_RET      = 8'h22;
  localparam logic [7:0] OP_RETI     = 8'h32;

  localparam int ALU_NOP  = 0;
  localparam int ALU_PASS = 1;
  localparam int ALU_ADD  = 2;
  localparam int ALU_SUBB = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_OR   = 5;
  localparam int ALU_XOR  = 6;
  localparam int ALU_TSTZ = 7;
  localparam int ALU_TSTC = 8;

  localparam int RAM_NONE     = 0;
  localparam int RD_RAM_RN    = 1;
  localparam int RD_RAM_IMM   = 2;
  localparam int RD_RAM_STACK = 3;
  localparam int WR_RAM_STACK = 4;

  function automatic logic [2:0] op_len(input logic [7:0] op);
    logic [2:0] len;
    len = 3'd1;
    case (op)
      OP_ADD_IMM, OP_SUBB_IMM, OP_ANL_IMM, OP_ORL_IMM, OP_XRL_IMM,
      OP_JZ, OP_JNZ, OP_JNC, OP_AJMP, OP_ACALL: len = 3'd2;
      OP_LJMP:                                  len = 3'd3;
      default:                                  len = 3'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/control_decode.sv
// Opcode decoder: instruction length (clamped to MAX_BYTES), RAM access code,
// ALU opcode and control-flow class. Purely combinational.
module control_decode
  import control_sequencer_pkg::*;
#(
  parameter int OPCODE_W  = 8,
  parameter int MAX_BYTES = 3,
  parameter int RAM_ACC_W = 4,
  parameter int ALU_OP_W  = 5
) (
  input  logic [OPCODE_W-1:0]  opcode,
  output logic [2:0]           len,
  output logic [RAM_ACC_W-1:0] ram_access,
  output logic [ALU_OP_W-1:0]  alu_opcode,
  output class_e               cls
);

  logic [7:0] op8;
  logic [2:0] raw_len;

  always_comb begin
    op8        = 8'(opcode);
    raw_len    = op_len(op8);
    len        = (raw_len > 3'(MAX_BYTES)) ? 3'(MAX_BYTES) : raw_len;
    ram_access = '0;
    alu_opcode = '0;
    cls        = CLS_NOP;
    if ((op8 & 8'hF8) == OP_MOV_A_RN) begin
      ram_access = RAM_ACC_W'(RD_RAM_RN);
      alu_opcode = ALU_OP_W'(ALU_PASS);
      cls        = CLS_ALU;
    end else begin
      case (op8)
        OP_ADD_IMM:  begin ram_access = RAM_ACC_W'(RD_RAM_IMM); alu_opcode = ALU_OP_W'(ALU_ADD);  cls = CLS_ALU; end
        OP_SUBB_IMM: begin ram_access = RAM_ACC_W'(RD_RAM_IMM); alu_opcode = ALU_OP_W'(ALU_SUBB); cls = CLS_ALU; end
        OP_ANL_IMM:  begin ram_access = RAM_ACC_W'(RD_RAM_IMM); alu_opcode = ALU_OP_W'(ALU_AND);  cls = CLS_ALU; end
        OP_ORL_IMM:  begin ram_access = RAM_ACC_W'(RD_RAM_IMM); alu_opcode = ALU_OP_W'(ALU_OR);   cls = CLS_ALU; end
        OP_XRL_IMM:  begin ram_access = RAM_ACC_W'(RD_RAM_IMM); alu_opcode = ALU_OP_W'(ALU_XOR);  cls = CLS_ALU; end
        OP_JZ, OP_JNZ: begin alu_opcode = ALU_OP_W'(ALU_TSTZ); cls = CLS_JUMP; end
        OP_JNC:        begin alu_opcode = ALU_OP_W'(ALU_TSTC); cls = CLS_JUMP; end
        OP_AJMP, OP_LJMP: cls = CLS_JUMP;
        OP_ACALL:      begin ram_access = RAM_ACC_W'(WR_RAM_STACK); cls = CLS_CALL; end
        OP_RET, OP_RETI: begin ram_access = RAM_ACC_W'(RD_RAM_STACK); cls = CLS_RET; end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-byte instruction fetch/decode/execute sequencer with wait-state
// handling and interrupt entry between instructions.
//
// state    | meaning
// S_START  | idle between instructions; sample int_req
// S_FETCH  | issue fetch of byte byte_idx (ir_load, pc_load)
// S_WAIT   | wait for min wait cycles and mem_ready (ram_load on exit)
// S_DECODE | decode_load strobe
// S_EXEC   | a_load, jmp_load for jump/call/return; clear decode results
// S_INT    | interrupt acknowledge, forced call
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int OPCODE_W    = 8,
  parameter int MAX_BYTES   = 3,
  parameter int WAIT_CYCLES = 1,
  parameter int RAM_ACC_W   = 4,
  parameter int ALU_OP_W    = 5,
  localparam int BIDX_W     = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic                 mem_ready,
  input  logic                 int_req,
  output logic                 ir_load,
  output logic                 pc_load,
  output logic                 ram_load,
  output logic                 decode_load,
  output logic                 a_load,
  output logic                 jmp_load,
  output logic                 int_ack,
  output logic                 busy,
  output logic [BIDX_W-1:0]    byte_idx,
  output logic [RAM_ACC_W-1:0] ram_access,
  output logic [ALU_OP_W-1:0]  alu_opcode
);

  state_e                state_q, state_d;
  logic [BIDX_W-1:0]     byte_idx_q, byte_idx_d;
  logic [2:0]            wait_cnt_q, wait_cnt_d;
  logic [2:0]            len_q, len_d;
  logic [RAM_ACC_W-1:0]  ram_acc_q, ram_acc_d;
  logic [ALU_OP_W-1:0]   alu_op_q, alu_op_d;
  class_e                cls_q, cls_d;

  logic [2:0]            dec_len;
  logic [RAM_ACC_W-1:0]  dec_ram;
  logic [ALU_OP_W-1:0]   dec_alu;
  class_e                dec_cls;
  logic                  wait_exit;
  logic [2:0]            len_eff;

  control_decode #(
    .OPCODE_W  (OPCODE_W),
    .MAX_BYTES (MAX_BYTES),
    .RAM_ACC_W (RAM_ACC_W),
    .ALU_OP_W  (ALU_OP_W)
  ) u_decode (
    .opcode     (opcode),
    .len        (dec_len),
    .ram_access (dec_ram),
    .alu_opcode (dec_alu),
    .cls        (dec_cls)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_START;
      byte_idx_q <= '0;
      wait_cnt_q <= '0;
      len_q      <= 3'd1;
      ram_acc_q  <= '0;
      alu_op_q   <= '0;
      cls_q      <= CLS_NOP;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      wait_cnt_q <= wait_cnt_d;
      len_q      <= len_d;
      ram_acc_q  <= ram_acc_d;
      alu_op_q   <= alu_op_d;
      cls_q      <= cls_d;
    end
  end

  always_comb begin
    wait_exit  = (state_q == S_WAIT) && (wait_cnt_q >= 3'(WAIT_CYCLES)) && mem_ready;
    // the first byte's exit decides the length from the live decode
    len_eff    = (byte_idx_q == '0) ? dec_len : len_q;
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    wait_cnt_d = 3'd0;
    len_d      = len_q;
    ram_acc_d  = ram_acc_q;
    alu_op_d   = alu_op_q;
    cls_d      = cls_q;
    case (state_q)
      S_START: begin
        if (int_req) begin
          state_d = S_INT;
        end else begin
          state_d    = S_FETCH;
          byte_idx_d = '0;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        wait_cnt_d = (wait_cnt_q == 3'd7) ? wait_cnt_q : wait_cnt_q + 3'd1;
        if (wait_exit) begin
          if (byte_idx_q == '0) begin
            len_d     = dec_len;
            ram_acc_d = dec_ram;
            alu_op_d  = dec_alu;
            cls_d     = dec_cls;
          end
          if (4'(byte_idx_q) + 4'd1 < 4'(len_eff)) begin
            state_d    = S_FETCH;
            byte_idx_d = byte_idx_q + BIDX_W'(1);
          end else begin
            state_d = S_DECODE;
          end
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        ram_acc_d  = '0;
        alu_op_d   = '0;
        byte_idx_d = '0;
        state_d    = S_START;
      end
      S_INT: begin
        cls_d   = CLS_CALL;
        state_d = S_START;
      end
      default: state_d = S_START;
    endcase
  end

  assign ir_load     = (state_q == S_FETCH);
  assign pc_load     = (state_q == S_FETCH);
  assign ram_load    = wait_exit;
  assign decode_load = (state_q == S_DECODE);
  assign a_load      = (state_q == S_EXEC);
  assign jmp_load    = ((state_q == S_EXEC) && (cls_q inside {CLS_JUMP, CLS_CALL, CLS_RET}))
                       || (state_q == S_INT);
  assign int_ack     = (state_q == S_INT);
  assign busy        = (state_q != S_START);
  assign byte_idx    = byte_idx_q;
  assign ram_access  = ram_acc_q;
  assign alu_opcode  = alu_op_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: builds the expected per-cycle trace of each
// instruction from its length, wait schedule and class, then replays it.
module tb_control_sequencer;
  import control_sequencer_pkg::*;

  localparam int W_A  = 1;
  localparam int MB_A = 3;
  localparam int W_B  = 0;
  localparam int MB_B = 2;

  localparam logic [7:0] M_IR = 8'h80, M_PC = 8'h40, M_RL = 8'h20, M_DL = 8'h10;
  localparam logic [7:0] M_AL = 8'h08, M_JL = 8'h04, M_ACK = 8'h02, M_BSY = 8'h01;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_a, reset_b, mem_ready, int_req, sel;
  logic [7:0] opcode;

  logic ir_a, pc_a, rl_a, dl_a, al_a, jl_a, ack_a, busy_a;
  logic ir_b, pc_b, rl_b, dl_b, al_b, jl_b, ack_b, busy_b;
  logic [1:0] bidx_a;
  logic [0:0] bidx_b;
  logic [3:0] ram_a, ram_b;
  logic [4:0] alu_a, alu_b;

  control_sequencer #(.OPCODE_W(8), .MAX_BYTES(MB_A), .WAIT_CYCLES(W_A), .RAM_ACC_W(4), .ALU_OP_W(5)) dut_a (
    .clock(clock), .reset(reset_a), .opcode(opcode), .mem_ready(mem_ready), .int_req(int_req),
    .ir_load(ir_a), .pc_load(pc_a), .ram_load(rl_a), .decode_load(dl_a), .a_load(al_a),
    .jmp_load(jl_a), .int_ack(ack_a), .busy(busy_a), .byte_idx(bidx_a),
    .ram_access(ram_a), .alu_opcode(alu_a));

  control_sequencer #(.OPCODE_W(8), .MAX_BYTES(MB_B), .WAIT_CYCLES(W_B), .RAM_ACC_W(4), .ALU_OP_W(5)) dut_b (
    .clock(clock), .reset(reset_b), .opcode(opcode), .mem_ready(mem_ready), .int_req(int_req),
    .ir_load(ir_b), .pc_load(pc_b), .ram_load(rl_b), .decode_load(dl_b), .a_load(al_b),
    .jmp_load(jl_b), .int_ack(ack_b), .busy(busy_b), .byte_idx(bidx_b),
    .ram_access(ram_b), .alu_opcode(alu_b));

  logic [7:0] obs_strb;
  logic [1:0] obs_bidx;
  logic [3:0] obs_ram;
  logic [4:0] obs_alu;

  always_comb begin
    if (sel) begin
      obs_strb = {ir_b, pc_b, rl_b, dl_b, al_b, jl_b, ack_b, busy_b};
      obs_bidx = 2'(bidx_b);
      obs_ram  = ram_b;
      obs_alu  = alu_b;
    end else begin
      obs_strb = {ir_a, pc_a, rl_a, dl_a, al_a, jl_a, ack_a, busy_a};
      obs_bidx = bidx_a;
      obs_ram  = ram_a;
      obs_alu  = alu_a;
    end
  end

  typedef struct {
    logic       mr;
    logic       irq;
    logic [7:0] opc;
    logic [7:0] strb;
    int         bidx;
    int         ram;
    int         alu;
  } cyc_t;

  cyc_t q[$];
  int   n_cmp, n_err, mark_idx;

  logic [7:0] ops [15] = '{8'hE9, 8'hE8, 8'hEF, 8'h24, 8'h94, 8'h54, 8'h44, 8'h64,
                           8'h60, 8'h70, 8'h50, 8'h01, 8'h11, 8'h02, 8'h22};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference decode taken from the instruction set: length, RAM code, ALU code, jump-class flag.
  task automatic ref_decode(input logic [7:0] op, output int len, output int ram,
                            output int alu, output bit jmp);
    len = 1; ram = RAM_NONE; alu = ALU_NOP; jmp = 1'b0;
    if (op[7:3] == 5'b11101) begin
      ram = RD_RAM_RN; alu = ALU_PASS;
    end else begin
      case (op)
        8'h24: begin len = 2; ram = RD_RAM_IMM; alu = ALU_ADD;  end
        8'h94: begin len = 2; ram = RD_RAM_IMM; alu = ALU_SUBB; end
        8'h54: begin len = 2; ram = RD_RAM_IMM; alu = ALU_AND;  end
        8'h44: begin len = 2; ram = RD_RAM_IMM; alu = ALU_OR;   end
        8'h64: begin len = 2; ram = RD_RAM_IMM; alu = ALU_XOR;  end
        8'h60, 8'h70: begin len = 2; alu = ALU_TSTZ; jmp = 1'b1; end
        8'h50: begin len = 2; alu = ALU_TSTC; jmp = 1'b1; end
        8'h01: begin len = 2; jmp = 1'b1; end
        8'h11: begin len = 2; ram = WR_RAM_STACK; jmp = 1'b1; end
        8'h02: begin len = 3; jmp = 1'b1; end
        8'h22, 8'h32: begin ram = RD_RAM_STACK; jmp = 1'b1; end
        default: ;
      endcase
    end
  endtask

  function automatic void push(input logic mr, input logic irq, input logic [7:0] opc,
                               input logic [7:0] strb, input int bidx, input int ram, input int alu);
    cyc_t r;
    r.mr = mr; r.irq = irq; r.opc = opc; r.strb = strb;
    r.bidx = bidx; r.ram = ram; r.alu = alu;
    q.push_back(r);
  endfunction

  // dly < 0 picks a random mem_ready delay per fetch, otherwise a fixed one
  task automatic build(input logic [7:0] op, input int mb, input int w, input bit irq, input int dly);
    int len, ram, alu, n, d, wc, cr, ca;
    bit jmp;
    logic [7:0] byt;
    ref_decode(op, len, ram, alu, jmp);
    n = (len > mb) ? mb : len;
    push(1'b0, 1'b0, op, 8'h00, 0, 0, 0);
    for (int k = 0; k < n; k++) begin
      byt = (k == 0) ? op : 8'($urandom);
      cr  = (k == 0) ? 0 : ram;
      ca  = (k == 0) ? 0 : alu;
      push(1'b0, irq, byt, M_IR | M_PC | M_BSY, k, cr, ca);
      d  = (dly < 0) ? int'($urandom_range(0, 4)) : dly;
      wc = ((w > d) ? w : d) + 1;
      for (int j = 0; j < wc; j++) begin
        if (k == 1 && j == 0) mark_idx = q.size();
        push((j >= d), irq, byt, M_BSY | ((j == wc - 1) ? M_RL : 8'h00), k, cr, ca);
      end
    end
    push(1'b0, irq, 8'($urandom), M_DL | M_BSY, n - 1, ram, alu);
    push(1'b0, irq, 8'($urandom), M_AL | M_BSY | (jmp ? M_JL : 8'h00), n - 1, ram, alu);
    if (irq) begin
      push(1'b0, 1'b1, 8'($urandom), 8'h00, 0, 0, 0);
      push(1'b0, 1'b0, 8'($urandom), M_ACK | M_JL | M_BSY, 0, 0, 0);
    end
  endtask

  task automatic play(input int upto);
    int lim;
    lim = (upto < 0) ? q.size() : upto;
    for (int i = 0; i < lim; i++) begin
      @(posedge clock);
      #1;
      if (sel) reset_b = 1'b0; else reset_a = 1'b0;
      mem_ready = q[i].mr;
      int_req   = q[i].irq;
      opcode    = q[i].opc;
      @(negedge clock);
      check($sformatf("cyc%0d.strobes", i), 32'(obs_strb), 32'(q[i].strb));
      check($sformatf("cyc%0d.byte_idx", i), 32'(obs_bidx), 32'(q[i].bidx));
      check($sformatf("cyc%0d.ram_access", i), 32'(obs_ram), 32'(q[i].ram));
      check($sformatf("cyc%0d.alu_opcode", i), 32'(obs_alu), 32'(q[i].alu));
    end
  endtask

  task automatic run(input logic [7:0] op, input int mb, input int w, input bit irq, input int dly);
    q.delete();
    build(op, mb, w, irq, dly);
    play(-1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".strobes"}, 32'(obs_strb), 32'h0);
    check({tag, ".byte_idx"}, 32'(obs_bidx), 32'h0);
    check({tag, ".ram_access"}, 32'(obs_ram), 32'h0);
    check({tag, ".alu_opcode"}, 32'(obs_alu), 32'h0);
  endtask

  function automatic logic [7:0] rand_op();
    if ($urandom_range(0, 4) == 0) return 8'($urandom);
    return ops[$urandom_range(0, 14)];
  endfunction

  initial begin
    n_cmp = 0; n_err = 0; mark_idx = 0;
    sel = 1'b0; reset_a = 1'b1; reset_b = 1'b1;
    mem_ready = 1'b0; int_req = 1'b0; opcode = 8'h00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_idle("reset");

    run(8'hE9, MB_A, W_A, 1'b0, 0);
    run(8'h24, MB_A, W_A, 1'b0, -1);
    run(8'h02, MB_A, W_A, 1'b0, -1);
    run(8'h24, MB_A, W_A, 1'b0, 5);
    run(8'h24, MB_A, W_A, 1'b1, -1);
    run(8'hA5, MB_A, W_A, 1'b0, -1);

    q.delete();
    build(8'h24, MB_A, W_A, 1'b0, -1);
    play(mark_idx + 1);
    reset_a = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check_idle("midwait_reset");

    for (int t = 0; t < 40; t++)
      run(rand_op(), MB_A, W_A, ($urandom_range(0, 3) == 0), -1);

    sel = 1'b1;
    reset_a = 1'b1;
    run(8'h02, MB_B, W_B, 1'b0, 0);
    run(8'h02, MB_B, W_B, 1'b0, -1);
    run(8'h24, MB_B, W_B, 1'b1, 0);
    for (int t = 0; t < 20; t++)
      run(rand_op(), MB_B, W_B, ($urandom_range(0, 3) == 0), -1);

    @(posedge clock);
    #1;
    int_req = 1'b0;
    @(negedge clock);
    check_idle("final_start");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
